secuenciador_instr: RTL



---
 rtl/secuenciador_instr.sv | 137 +++++++++++++
 1 files changed

// File: rtl/secuenciador_instr.sv
// Purpose: program-memory instruction sequencer driving the single-cycle datapath's INSTRUCCION bus (optional loop mode via SECUENCIADOR_BUCLE_EN).
// Latency: INICIO sampled at edge k -> mem[0] on INSTRUCCION from edge k+1; FIN pulses one cycle after the last word.
// Backpressure: PAUSA=1 in RUN issues a NOP and holds PC; resume continues from the held PC with no loss or duplication.
module secuenciador_instr #(
    parameter int AW    = 4,
    parameter int DEPTH = 16,
    parameter int IW    = 20
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CARGA_WE,
    input  logic [AW-1:0] CARGA_DIR,
    input  logic [IW-1:0] CARGA_DATO,
    input  logic [AW:0]   LONGITUD,
    input  logic          INICIO,
    input  logic          PAUSA,
`ifdef SECUENCIADOR_BUCLE_EN
    input  logic          BUCLE,
`endif
    output logic [IW-1:0] INSTRUCCION,
    output logic          VALIDO,
    output logic          OCUPADO,
    output logic [AW-1:0] PC,
    output logic          FIN
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} estado_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    estado_t       state_q, state_d;
    logic [AW-1:0] pc_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   len_ini;
    logic [IW-1:0] instr_d;
    logic          valido_d;
    logic          ocupado_d;
    logic          fin_d;
    logic          fin_pend_q, fin_pend_d;
    logic          ultimo;
    logic          bucle;
    logic          dir_ok;

    logic [IW-1:0] mem [DEPTH];

`ifdef SECUENCIADOR_BUCLE_EN
    assign bucle = BUCLE;
`else
    assign bucle = 1'b0;
`endif

    // Writes beyond the last program word are dropped; when DEPTH fills the
    // address space every address is legal.
    generate
        if (DEPTH < 2**AW) begin : g_dir_chk
            assign dir_ok = ({1'b0, CARGA_DIR} < DEPTH_L);
        end else begin : g_dir_full
            assign dir_ok = 1'b1;
        end
    endgenerate

    assign len_ini = (LONGITUD > DEPTH_L) ? DEPTH_L : LONGITUD;
    assign ultimo  = ({1'b0, PC} == (len_q - (AW+1)'(1)));

    // Program memory: loaded only while idle, never cleared by reset.
    always_ff @(posedge CLK) begin
        if (state_q == IDLE && CARGA_WE && dir_ok)
            mem[CARGA_DIR] <= CARGA_DATO;
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            PC          <= '0;
            len_q       <= '0;
            INSTRUCCION <= '0;
            VALIDO      <= 1'b0;
            OCUPADO     <= 1'b0;
            FIN         <= 1'b0;
            fin_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            PC          <= pc_d;
            len_q       <= len_d;
            INSTRUCCION <= instr_d;
            VALIDO      <= valido_d;
            OCUPADO     <= ocupado_d;
            FIN         <= fin_d;
            fin_pend_q  <= fin_pend_d;
        end
    end

    // Next-state and issue logic; NOP is the default output.
    always_comb begin
        state_d    = state_q;
        pc_d       = PC;
        len_d      = len_q;
        instr_d    = '0;
        valido_d   = 1'b0;
        fin_d      = 1'b0;
        fin_pend_d = 1'b0;
        case (state_q)
            IDLE: begin
                // FIN lands one cycle after the last word was put on the bus.
                fin_d = fin_pend_q;
                if (INICIO) begin
                    if (len_ini == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        len_d   = len_ini;
                        pc_d    = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!PAUSA) begin
                    instr_d  = mem[PC];
                    valido_d = 1'b1;
                    pc_d     = PC + AW'(1);
                    if (ultimo) begin
                        pc_d = '0;
                        if (!bucle) begin
                            state_d    = IDLE;
                            fin_pend_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Busy stays up through the cycle that shows the last word.
        ocupado_d = (state_d == RUN) || (state_q == RUN);
    end

endmodule
